mem_arb: RTL and testbench
==========================

# mem_arb

Two-master memory-port arbiter and sequencer. It shares the single external memory port between instruction fetch (master 0) and the MEM-stage load/store path (master 1). It sits between the pipeline and the bus slave, issues one transaction at a time with round-robin arbitration, and raises per-master stall requests toward the pipeline controller. It also discards fetch data that is still in flight when the pipeline is flushed.

## Interface
- AW, 32, address width
- DW, 32, data width; byte-select width is DW/8

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; cancels or discards the fetch transaction
- m0_req_i  in  1  fetch request; held until m0_ack_o
- m0_addr_i  in  AW  fetch address
- m0_rdata_o  out  DW  fetch data; valid when m0_ack_o
- m0_ack_o  out  1  one-cycle completion pulse
- stallreq_if_o  out  1  fetch stall request
- m1_req_i  in  1  data request; held until m1_ack_o
- m1_we_i  in  1  1 = store
- m1_sel_i  in  DW/8  byte enables
- m1_addr_i  in  AW  data address
- m1_wdata_i  in  DW  store data
- m1_rdata_o  out  DW  load data; valid when m1_ack_o
- m1_ack_o  out  1  one-cycle completion pulse
- stallreq_mem_o  out  1  data stall request
- s_cyc_o, s_stb_o  out  1  bus cycle / strobe; always equal
- s_we_o  out  1  write enable
- s_sel_o  out  DW/8  byte enables; all ones for fetch
- s_addr_o  out  AW  address
- s_wdata_o  out  DW  write data
- s_rdata_i  in  DW  read data
- s_ack_i  in  1  slave completion; may arrive in the first strobe cycle

## Operation
- States: IDLE, BUSY_M0, BUSY_M1, DRAIN. Extra register: last_grant (1 bit).
- Effective requests in IDLE:
  - r0 = m0_req_i & ~flush & ~m0_ack_o.
  - r1 = m1_req_i & ~m1_ack_o.
  - Masking by ack prevents a re-grant in the cycle a master sees its ack.
- Arbitration in IDLE:
  - Only r1 → BUSY_M1. Only r0 → BUSY_M0.
  - Both → grant the master that is not last_grant.
  - On grant, last_grant is updated and all s_* outputs are registered from the winning master.
- BUSY_Mx:
  - s_cyc_o and s_stb_o are held high, with all s_* outputs stable.
  - On s_ack_i: register s_rdata_i into mx_rdata_o, pulse mx_ack_o on the next cycle, drop s_stb_o, go to IDLE.
- Flush:
  - In BUSY_M0 without s_ack_i → DRAIN.
  - In BUSY_M0 with s_ack_i in the same cycle → IDLE with no m0_ack_o.
  - In DRAIN: keep the strobe until s_ack_i, discard the data, never pulse m0_ack_o, then → IDLE.
  - In BUSY_M1 or DRAIN: no effect, because stores must complete.
- Stall outputs (combinational):
  - stallreq_if_o = m0_req_i & ~m0_ack_o & ~flush.
  - stallreq_mem_o = m1_req_i & ~m1_ack_o.
- mx_rdata_o holds its value until the next completion for that master. Store completions load s_rdata_i as well; the value is don't-care.

## Timing
- Reset:
  - state = IDLE; last_grant = M0, so M1 wins the first tie.
  - Every output = 0.
  - Reset mid-transaction aborts immediately; the strobe drops asynchronously.
- Latency:
  - Request seen in IDLE at cycle T → s_stb_o high from T+1.
  - s_ack_i at T+1 → mx_ack_o at T+2. Minimum 2 cycles; one extra cycle per slave wait state.
- Back-to-back requests from one master:
  - Next grant is decided at T+3 (T+2 is masked), strobe at T+4.
  - Peak throughput is one transaction per 3 cycles.
- With both masters requesting continuously, grants strictly alternate.
- Flush is sampled synchronously.

## Structure
- Shared package (defines): state encoding (2 bits), master IDs M0/M1, and the all-ones byte select.
- One natural sub-module: rr_pick2, a combinational two-way round-robin selector driven by r0, r1 and last_grant.
- Everything else (FSM, output registers, drain) stays in mem_arb.

## Test plan
- Reset with m0_req_i=1 → all outputs 0. After rst rises: s_stb_o=1, s_addr_o=m0_addr_i at the next edge; s_ack_i next cycle with s_rdata_i=0x24010001 → m0_ack_o pulses once with m0_rdata_o=0x24010001.
- Both masters request at the same time, 0-wait slave → grant order M1, M0, M1, M0. No cycle has both acks high.
- Store: m1_we_i=1, m1_sel_i=4'b0011, m1_addr_i=0x100, m1_wdata_i=0xDEADBEEF, slave with 3 wait states → s_we_o=1, s_sel_o=0011, s_wdata_o=0xDEADBEEF, all stable for 4 strobe cycles. stallreq_mem_o=1 until m1_ack_o.
- Flush in the second cycle of a 3-wait fetch → DRAIN. Strobe held until s_ack_i, no m0_ack_o. A new fetch to 0x20 is granted afterwards and completes normally.
- Flush in the same cycle as s_ack_i during BUSY_M0 → no m0_ack_o, m0_rdata_o unchanged. Flush during BUSY_M1 → m1_ack_o is still delivered.
- Drop rst mid-transaction (BUSY_M1, 2 wait states) → s_stb_o=0 and all outputs 0 immediately. After release, the first tie goes to M1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory-port arbiter.
// State encoding, master ids and the full byte-select mask.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_M0 = 2'd1,
    S_BUSY_M1 = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_e;

  localparam int SW_MAX = 16;
  localparam logic [SW_MAX-1:0] SEL_ALL = '1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector.
// On a tie the master that did not win last time is chosen.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic r0_i,
  input  logic r1_i,
  input  mst_e last_i,
  output logic gnt_o,
  output mst_e id_o
);

  always_comb begin
    gnt_o = r0_i | r1_i;
    id_o  = M0;
    unique case (1'b1)
      (r0_i & r1_i):  id_o = (last_i == M0) ? M1 : M0;
      (r1_i & ~r0_i): id_o = M1;
      default:        id_o = M0;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Fetch / load-store arbiter onto one memory port.
// One transaction in flight; flushed fetches are drained silently.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            m0_req_i,
  input  logic [AW-1:0]   m0_addr_i,
  output logic [DW-1:0]   m0_rdata_o,
  output logic            m0_ack_o,
  output logic            stallreq_if_o,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_addr_i,
  input  logic [DW-1:0]   m1_wdata_i,
  output logic [DW-1:0]   m1_rdata_o,
  output logic            m1_ack_o,
  output logic            stallreq_mem_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_addr_o,
  output logic [DW-1:0]   s_wdata_o,
  input  logic [DW-1:0]   s_rdata_i,
  input  logic            s_ack_i
);

  state_e          state_q, state_d;
  mst_e            last_q, last_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [DW/8-1:0] sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rd0_q, rd0_d;
  logic [DW-1:0]   rd1_q, rd1_d;

  logic r0, r1, gnt;
  mst_e gid;

  // A master is invisible in the cycle it sees its ack.
  assign r0 = m0_req_i & ~flush & ~ack0_q;
  assign r1 = m1_req_i & ~ack1_q;

  rr_pick2 u_pick (
    .r0_i   (r0),
    .r1_i   (r1),
    .last_i (last_q),
    .gnt_o  (gnt),
    .id_o   (gid)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt) begin
          last_d = gid;
          stb_d  = 1'b1;
          if (gid == M1) begin
            state_d = S_BUSY_M1;
            we_d    = m1_we_i;
            sel_d   = m1_sel_i;
            addr_d  = m1_addr_i;
            wdata_d = m1_wdata_i;
          end else begin
            state_d = S_BUSY_M0;
            we_d    = 1'b0;
            sel_d   = SEL_ALL[DW/8-1:0];
            addr_d  = m0_addr_i;
            wdata_d = '0;
          end
        end
      end
      S_BUSY_M0: begin
        if (s_ack_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
          if (!flush) begin
            ack0_d = 1'b1;
            rd0_d  = s_rdata_i;
          end
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_BUSY_M1: begin
        if (s_ack_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
          ack1_d  = 1'b1;
          rd1_d   = s_rdata_i;
        end
      end
      S_DRAIN: begin
        if (s_ack_i) begin
          stb_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      last_q  <= M0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign s_cyc_o    = stb_q;
  assign s_stb_o    = stb_q;
  assign s_we_o     = we_q;
  assign s_sel_o    = sel_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;
  assign m0_ack_o   = ack0_q;
  assign m1_ack_o   = ack1_q;
  assign m0_rdata_o = rd0_q;
  assign m1_rdata_o = rd1_q;

  // Gated by reset so every output reads zero while held in reset.
  assign stallreq_if_o  = rst & m0_req_i & ~ack0_q & ~flush;
  assign stallreq_mem_o = rst & m1_req_i & ~ack1_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: vector table, directed corner cases and a
// randomized two-master run against a transaction-level model.
module tb_mem_arb;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        mst;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          lat;
    logic [3:0]  esel;
    logic        ewe;
  } vec_t;

  logic clk = 0;
  logic rst;
  logic flush;
  logic m0_req_i;
  logic [31:0] m0_addr_i;
  logic [31:0] m0_rdata_o;
  logic m0_ack_o, stallreq_if_o;
  logic m1_req_i, m1_we_i;
  logic [3:0] m1_sel_i;
  logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
  logic m1_ack_o, stallreq_mem_o;
  logic s_cyc_o, s_stb_o, s_we_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
  logic s_ack_i;

  mem_arb #(.AW(32), .DW(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .m0_req_i       (m0_req_i),
    .m0_addr_i      (m0_addr_i),
    .m0_rdata_o     (m0_rdata_o),
    .m0_ack_o       (m0_ack_o),
    .stallreq_if_o  (stallreq_if_o),
    .m1_req_i       (m1_req_i),
    .m1_we_i        (m1_we_i),
    .m1_sel_i       (m1_sel_i),
    .m1_addr_i      (m1_addr_i),
    .m1_wdata_i     (m1_wdata_i),
    .m1_rdata_o     (m1_rdata_o),
    .m1_ack_o       (m1_ack_o),
    .stallreq_mem_o (stallreq_mem_o),
    .s_cyc_o        (s_cyc_o),
    .s_stb_o        (s_stb_o),
    .s_we_o         (s_we_o),
    .s_sel_o        (s_sel_o),
    .s_addr_o       (s_addr_o),
    .s_wdata_o      (s_wdata_o),
    .s_rdata_i      (s_rdata_i),
    .s_ack_i        (s_ack_i)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  int   slv_waits = 0;
  bit   slv_rand  = 0;
  bus_t log_q[$];

  int m0_acks = 0, m1_acks = 0;
  int both_err = 0, stab_err = 0, stall_err = 0, cyc_err = 0;
  int order_q[$];

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h2401_0001;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave: acks after a configurable number of wait states.
  initial begin : slave
    int wcnt;
    int cur_w;
    wcnt = 0;
    cur_w = 0;
    s_ack_i = 0;
    s_rdata_i = 0;
    forever begin
      @(posedge clk);
      #1;
      s_rdata_i = $urandom;
      if (!rst || !s_stb_o) begin
        s_ack_i = 0;
        wcnt = 0;
      end else begin
        if (wcnt == 0)
          cur_w = slv_rand ? int'($urandom_range(0, 3)) : slv_waits;
        if (wcnt == cur_w) begin
          s_ack_i = 1;
          s_rdata_i = rd_of(s_addr_o);
          log_q.push_back({s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o});
        end else begin
          s_ack_i = 0;
        end
        wcnt++;
      end
    end
  end

  // Monitor: ack bookkeeping, bus stability and stall rules.
  initial begin : monitor
    bus_t prev;
    logic pstb;
    logic e_if, e_mem;
    pstb = 0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (m0_ack_o) begin m0_acks++; order_q.push_back(0); end
      if (m1_ack_o) begin m1_acks++; order_q.push_back(1); end
      if (m0_ack_o && m1_ack_o) both_err++;
      if (s_cyc_o !== s_stb_o) cyc_err++;
      if (s_stb_o && pstb &&
          prev !== {s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o})
        stab_err++;
      prev = {s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o};
      pstb = s_stb_o;
      e_if  = rst & m0_req_i & ~m0_ack_o & ~flush;
      e_mem = rst & m1_req_i & ~m1_ack_o;
      if (stallreq_if_o !== e_if || stallreq_mem_o !== e_mem) stall_err++;
    end
  end

  task automatic pulse_rst();
    @(negedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    #1 rst = 1;
  endtask

  task automatic wait_ack(input logic mst, input int maxc, output bit ok);
    int n;
    n = 0;
    ok = 0;
    while (n < maxc) begin
      @(negedge clk);
      if ((mst ? m1_ack_o : m0_ack_o) === 1'b1) begin
        ok = 1;
        break;
      end
      n++;
    end
    #1;
    if (mst) m1_req_i = 0;
    else m0_req_i = 0;
  endtask

  task automatic run_one(input vec_t v, output int lat,
                         output logic [31:0] rdata, output bus_t bus,
                         output bit stall_ok, output int scyc);
    logic a, st;
    slv_waits = v.waits;
    tick();
    if (v.mst) begin
      m1_req_i = 1; m1_we_i = v.we; m1_sel_i = v.sel;
      m1_addr_i = v.addr; m1_wdata_i = v.wdata;
    end else begin
      m0_req_i = 1; m0_addr_i = v.addr;
    end
    lat = 0; stall_ok = 1; bus = '0; scyc = 0;
    forever begin
      @(negedge clk);
      a  = v.mst ? m1_ack_o : m0_ack_o;
      st = v.mst ? stallreq_mem_o : stallreq_if_o;
      if (a) begin
        if (st) stall_ok = 0;
        break;
      end
      if (!st) stall_ok = 0;
      if (s_stb_o) scyc++;
      if (lat == 1) bus = {s_stb_o, s_we_o, s_sel_o, s_addr_o, s_wdata_o};
      lat++;
      if (lat > 60) break;
    end
    rdata = v.mst ? m1_rdata_o : m0_rdata_o;
    #1;
    m0_req_i = 0;
    m1_req_i = 0;
  endtask

  vec_t vecs[6];
  int   exp_order[4] = '{1, 0, 1, 0};

  initial begin
    int lat, scyc, c0, c1, n0, n1, sb;
    logic [31:0] rd;
    bus_t b;
    bit sok, ok;

    rst = 0; flush = 0;
    m0_req_i = 1; m0_addr_i = 32'h0;
    m1_req_i = 0; m1_we_i = 0; m1_sel_i = 0;
    m1_addr_i = 0; m1_wdata_i = 0;

    // Reset with a fetch pending, then the first fetch.
    repeat (2) @(negedge clk);
    check("rst_outputs_zero",
          |{m0_rdata_o, m0_ack_o, stallreq_if_o, m1_rdata_o, m1_ack_o,
            stallreq_mem_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
            s_addr_o, s_wdata_o}, 0);
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("first_stb", s_stb_o, 1);
    check("first_addr", s_addr_o, 32'h0);
    @(negedge clk);
    check("first_ack_early", m0_ack_o, 0);
    @(negedge clk);
    check("first_ack", m0_ack_o, 1);
    check("first_rdata", m0_rdata_o, 32'h2401_0001);
    #1 m0_req_i = 0;
    repeat (3) @(negedge clk);
    check("first_ack_once", m0_acks, 1);

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         0, 2, 4'hF, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h1111_1111, 1, 3, 4'hF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h0000_0100, 32'hDEAD_BEEF, 3, 5, 4'h3, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 4'h1, 32'h0000_1000, 32'h0,         2, 4, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'h8, 32'hFFFF_FFFC, 32'h0,         0, 2, 4'h8, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'hFFFF_FFFC, 32'h0,         5, 7, 4'hF, 1'b0};

    for (int i = 0; i < 6; i++) begin
      sb = stab_err;
      run_one(vecs[i], lat, rd, b, sok, scyc);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_strobe_cycles", i), scyc, vecs[i].waits + 1);
      check($sformatf("v%0d_stb", i), b.stb, 1);
      check($sformatf("v%0d_we", i), b.we, vecs[i].ewe);
      check($sformatf("v%0d_sel", i), b.sel, vecs[i].esel);
      check($sformatf("v%0d_addr", i), b.addr, vecs[i].addr);
      if (vecs[i].mst)
        check($sformatf("v%0d_wdata", i), b.wdata, vecs[i].wdata);
      if (!vecs[i].ewe)
        check($sformatf("v%0d_rdata", i), rd, rd_of(vecs[i].addr));
      check($sformatf("v%0d_stall", i), sok, 1);
      check($sformatf("v%0d_stable", i), stab_err - sb, 0);
    end

    // Simultaneous requests from reset: strict alternation.
    pulse_rst();
    slv_waits = 0;
    order_q.delete();
    tick();
    m0_req_i = 1; m0_addr_i = 32'h600;
    m1_req_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_addr_i = 32'h700;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40 && (n0 < 2 || n1 < 2); k++) begin
      @(negedge clk);
      if (m0_ack_o) n0++;
      if (m1_ack_o) n1++;
      #1;
      if (m0_ack_o) begin
        if (n0 >= 2) m0_req_i = 0; else m0_addr_i += 4;
      end
      if (m1_ack_o) begin
        if (n1 >= 2) m1_req_i = 0; else m1_addr_i += 4;
      end
    end
    m0_req_i = 0; m1_req_i = 0;
    check("tie_count", order_q.size(), 4);
    for (int k = 0; k < 4 && k < order_q.size(); k++)
      check($sformatf("tie_order%0d", k), order_q[k], exp_order[k]);

    // Flush during a 3-wait fetch: drain, then refetch 0x20.
    slv_waits = 3;
    c0 = m0_acks;
    log_q.delete();
    tick();
    m0_req_i = 1; m0_addr_i = 32'h80;
    tick();
    tick();
    flush = 1; m0_addr_i = 32'h20;
    tick();
    flush = 0;
    check("drain_stb", s_stb_o, 1);
    check("drain_addr", s_addr_o, 32'h80);
    wait_ack(0, 40, ok);
    check("drain_refetch_done", ok, 1);
    check("drain_refetch_rdata", m0_rdata_o, rd_of(32'h20));
    check("drain_ack_count", m0_acks - c0, 1);
    check("drain_bus_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("drain_bus0_addr", log_q[0].addr, 32'h80);
      check("drain_bus1_addr", log_q[1].addr, 32'h20);
    end

    // Flush in the same cycle as the slave ack.
    slv_waits = 1;
    c0 = m0_acks;
    tick();
    m0_req_i = 1; m0_addr_i = 32'h90;
    tick();
    tick();
    flush = 1; m0_req_i = 0;
    tick();
    flush = 0;
    check("flush_ack_idle", s_stb_o, 0);
    repeat (4) @(negedge clk);
    check("flush_ack_no_ack", m0_acks - c0, 0);
    check("flush_ack_rdata_held", m0_rdata_o, rd_of(32'h20));

    // Flush while the data port owns the bus.
    slv_waits = 2;
    c1 = m1_acks;
    tick();
    m1_req_i = 1; m1_we_i = 0; m1_sel_i = 4'hF; m1_addr_i = 32'h500;
    tick();
    flush = 1;
    tick();
    tick();
    flush = 0;
    wait_ack(1, 20, ok);
    check("m1_flush_done", ok, 1);
    check("m1_flush_rdata", m1_rdata_o, rd_of(32'h500));
    check("m1_flush_count", m1_acks - c1, 1);

    // Reset in the middle of a data transaction.
    slv_waits = 2;
    tick();
    m1_req_i = 1; m1_we_i = 1; m1_sel_i = 4'h5;
    m1_addr_i = 32'h300; m1_wdata_i = 32'hCAFE_F00D;
    tick();
    #1 rst = 0;
    #1;
    check("rstmid_stb", s_stb_o, 0);
    check("rstmid_outputs_zero",
          |{m0_rdata_o, m0_ack_o, stallreq_if_o, m1_rdata_o, m1_ack_o,
            stallreq_mem_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
            s_addr_o, s_wdata_o}, 0);
    m0_req_i = 1; m0_addr_i = 32'h400;
    @(negedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("rstmid_tie_m1_addr", s_addr_o, 32'h300);
    check("rstmid_tie_m1_we", s_we_o, 1);
    wait_ack(1, 20, ok);
    check("rstmid_m1_done", ok, 1);
    wait_ack(0, 20, ok);
    check("rstmid_m0_done", ok, 1);

    // Randomized traffic from both masters.
    repeat (3) @(negedge clk);
    log_q.delete();
    slv_rand = 1;
    fork
      begin : rnd_m0
        logic [31:0] a0;
        int snap0, w0;
        bus_t e0;
        for (int i = 0; i < 60; i++) begin
          tick();
          repeat ($urandom_range(0, 3)) tick();
          a0 = $urandom & 32'hFFFF_FFFC;
          m0_req_i = 1; m0_addr_i = a0;
          snap0 = m1_acks;
          w0 = 0;
          while (w0 < 100) begin
            @(negedge clk);
            if (m0_ack_o) break;
            w0++;
          end
          #1 m0_req_i = 0;
          check("rnd_m0_done", w0 < 100, 1);
          check("rnd_m0_rdata", m0_rdata_o, rd_of(a0));
          check("rnd_m0_fair", (m1_acks - snap0) <= 1, 1);
          if (log_q.size() > 0) begin
            e0 = log_q.pop_front();
            check("rnd_m0_bus", {e0.we, e0.sel, e0.addr}, {1'b0, 4'hF, a0});
          end else check("rnd_m0_bus_seen", 0, 1);
        end
      end
      begin : rnd_m1
        logic [31:0] a1, d1;
        logic        we1;
        logic [3:0]  sl1;
        int snap1, w1;
        bus_t e1;
        for (int i = 0; i < 60; i++) begin
          tick();
          repeat ($urandom_range(0, 3)) tick();
          a1 = $urandom & 32'hFFFF_FFFC;
          d1 = $urandom;
          we1 = 1'($urandom_range(0, 1));
          sl1 = 4'($urandom_range(1, 15));
          m1_req_i = 1; m1_we_i = we1; m1_sel_i = sl1;
          m1_addr_i = a1; m1_wdata_i = d1;
          snap1 = m0_acks;
          w1 = 0;
          while (w1 < 100) begin
            @(negedge clk);
            if (m1_ack_o) break;
            w1++;
          end
          #1 m1_req_i = 0;
          check("rnd_m1_done", w1 < 100, 1);
          if (!we1) check("rnd_m1_rdata", m1_rdata_o, rd_of(a1));
          check("rnd_m1_fair", (m0_acks - snap1) <= 1, 1);
          if (log_q.size() > 0) begin
            e1 = log_q.pop_front();
            check("rnd_m1_bus", {e1.we, e1.sel, e1.addr}, {we1, sl1, a1});
            if (we1) check("rnd_m1_wdata", e1.wdata, d1);
          end else check("rnd_m1_bus_seen", 0, 1);
        end
      end
    join
    slv_rand = 0;

    repeat (3) @(negedge clk);
    check("never_both_acks", both_err, 0);
    check("strobe_stable", stab_err, 0);
    check("stall_rules", stall_err, 0);
    check("cyc_eq_stb", cyc_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
